// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : Iterative restoring divider, one quotient bit per cycle, with a
//            start/done handshake. Signed support is built with the macro
//            DIVIDER_SIGNED_EN; without it every division is unsigned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   count_q, count_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     remo_q, remo_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     w_dvd_mag;
  logic [WIDTH-1:0]     w_dvs_mag;
  logic [WIDTH:0]       w_shifted;
  logic [WIDTH+1:0]     w_diff;
  logic                 w_borrow;
  logic                 w_unused_bits;

`ifdef DIVIDER_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic w_dvd_neg;
  logic w_dvs_neg;

  assign w_dvd_neg     = signed_op & dividend[WIDTH-1];
  assign w_dvs_neg     = signed_op & divisor[WIDTH-1];
  assign w_dvd_mag     = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag     = w_dvs_neg ? (~divisor + 1'b1) : divisor;
  assign w_unused_bits = w_diff[WIDTH];
`else
  assign w_dvd_mag     = dividend;
  assign w_dvs_mag     = divisor;
  assign w_unused_bits = ^{w_diff[WIDTH], signed_op};
`endif

  // Remainder stays below the divisor, so the shifted value fits in WIDTH+1
  // bits and the extra top bit of the difference is the borrow.
  assign w_shifted = {rem_q, q_q[WIDTH-1]};
  assign w_diff    = {1'b0, w_shifted} - {2'b00, dvs_q};
  assign w_borrow  = w_diff[WIDTH+1];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          rem_d   = '0;
          count_d = '0;
          dvs_d   = w_dvs_mag;
          q_d     = w_dvd_mag;
`ifdef DIVIDER_SIGNED_EN
          negq_d  = w_dvd_neg ^ w_dvs_neg;
          negr_d  = w_dvd_neg;
`endif
          if (divisor == '0) begin
            // Raw dividend parked in the quotient register for FIX to copy out.
            dz_d    = 1'b1;
            q_d     = dividend;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        q_d     = {q_q[WIDTH-2:0], ~w_borrow};
        rem_d   = w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
        count_d = count_q + 1'b1;
        if (count_q == c_last) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        state_d = S_IDLE;
        if (dz_q) begin
          quot_d = '1;
          remo_d = q_q;
        end else begin
`ifdef DIVIDER_SIGNED_EN
          quot_d = negq_q ? (~q_q + 1'b1) : q_q;
          remo_d = negr_q ? (~rem_q + 1'b1) : rem_q;
`else
          quot_d = q_q;
          remo_d = rem_q;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module   : tb_seq_restoring_divider
// Purpose  : Scoreboard bench for seq_restoring_divider (WIDTH=32); expected
//            results come from a behavioural divide model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  localparam int W = 32;
`ifdef DIVIDER_SIGNED_EN
  localparam bit c_signed_en = 1'b1;
`else
  localparam bit c_signed_en = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   n_cmp = 0;
  int   n_err = 0;
  int   ecount = 0;
  exp_t sb[$];
  exp_t last_exp;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sb_v, qq, rr;
    e.acc = 0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s && c_signed_en) begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      qq   = sa / sb_v;
      rr   = sa % sb_v;
      e.q  = qq[W-1:0];
      e.r  = rr[W-1:0];
      e.dz = 1'b0;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency", W'(ecount - e.acc + 1), e.dz ? W'(2) : W'(W + 2));
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    @(posedge clk);
    #1;
    e        = model(a, b, s);
    e.acc    = ecount;
    sb.push_back(e);
    last_exp = e;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", W'(sb.size()), '0);
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, '0);
    chk("rst_done", {31'd0, done}, '0);
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_dbz", {31'd0, div_by_zero}, '0);
    rst = 1'b0;
    @(negedge clk);

    do_op(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("hold_quotient", quotient, last_exp.q);
    chk("hold_remainder", remainder, last_exp.r);

    do_op(32'hFFFFFF9C, 32'd7, 1'b1);
    wait_drain();
    do_op(32'd100, 32'hFFFFFFF9, 1'b1);
    wait_drain();
    do_op(32'h12345678, 32'd0, 1'b0);
    wait_drain();
    do_op(32'h87654321, 32'd0, 1'b1);
    wait_drain();
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_drain();
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_drain();
    do_op(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_drain();
    do_op(32'd5, 32'd9, 1'b0);
    wait_drain();

    // A start pulse mid-operation must be ignored.
    do_op(32'd1000, 32'd33, 1'b0);
    repeat (5) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Back-to-back: second start issued in the done cycle of the first.
    do_op(32'd123456, 32'd100, 1'b0);
    @(negedge clk);
    wait_done();
    do_op(32'hDEADBEEF, 32'h1234, 1'b1);
    wait_drain();

    // Abort at iteration 10 with reset.
    do_op(32'hCAFEF00D, 32'd13, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, '0);
    chk("abort_done", {31'd0, done}, '0);
    chk("abort_quotient", quotient, '0);
    chk("abort_remainder", remainder, '0);
    chk("abort_dbz", {31'd0, div_by_zero}, '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    do_op(32'd999, 32'd10, 1'b0);
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      do_op($urandom, (i == 3) ? 32'd0 : ($urandom >> (i * 3)), 1'($urandom_range(0, 1)));
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
